xrv_dmem: RTL and testbench
===========================

Name: xrv_dmem

Overview:
- Data-memory responder for the core's d_* load/store port; the target side of that handshake.
- Serves word reads and byte-enabled writes from a local synchronous RAM, with a configurable wait-state count.
- Flags accesses outside its address window.
- Sits between the execute stage's data port and on-chip block RAM.

Parameters:
- DEPTH, 4096: RAM size in 32-bit words; power of 2.
- BASE, 32'h0001_0000: byte base address of the RAM window; aligned to DEPTH*4.
- WAIT_CYCLES, 0: extra stall cycles inserted before each response, range 0..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; one clock, asynchronous, active-high.
- d_addr  in  32  byte address; valid while a request is high.
- d_wr_req  in  1  write request; held high until d_wr_ready is seen.
- d_be  in  4  byte lane enables for writes; ignored for reads.
- d_wr_data  in  32  lane-aligned write data.
- d_wr_ready  out  1  one-cycle write completion pulse.
- d_rd_req  in  1  read request; held high until d_rd_ready is seen.
- d_rd_ready  out  1  one-cycle read completion pulse; d_rd_data is valid in the same cycle.
- d_rd_data  out  32  full word read; the initiator extracts byte and half lanes.
- err  out  1  sticky out-of-window flag; cleared only by rst.
- err_addr  out  32  d_addr of the first out-of-window access.
- con_valid  out  1  console byte strobe (MMIO feature).
- con_data  out  8  console byte (MMIO feature).

Behaviour:
- Reset values: state IDLE; d_wr_ready=0, d_rd_ready=0, d_rd_data=0, err=0, err_addr=0, con_valid=0, con_data=0, counters 0. RAM contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: if d_wr_req|d_rd_req, capture addr/be/wdata/op. Write wins if both requests are high; the read is served on a later pass. Load cnt=WAIT_CYCLES, then go to WAIT if cnt>0, else ACCESS.
- WAIT: decrement cnt; at cnt==1 go to ACCESS.
- ACCESS:
  - In-window: RAM index = (addr-BASE)[log2(DEPTH)+1:2]. Writes update only lanes with be[i]=1. Reads present the index to the synchronous RAM.
  - Out-of-window: write is dropped; read returns 32'h0.
  - err sets on the first out-of-window access; err_addr latches only while err==0.
  - Go to RESP.
- RESP: assert the matching ready for exactly one cycle; d_rd_data is held until the next read's RESP. Go to IDLE.
- Latency: if a request is first high in cycle N, ready is high in cycle N+2+WAIT_CYCLES. addr[1:0] is ignored for indexing.
- Ready is never high in two consecutive cycles. The initiator drops its request the cycle after ready, so IDLE cannot re-accept the same request.
- Requests rising during WAIT/ACCESS/RESP are not sampled until IDLE.
- Asynchronous rst mid-transaction: return to IDLE, no ready pulse. A write already in ACCESS may have committed.

Optional Feature:
- Macro XRV_DMEM_MMIO_EN.
- Defined, the following addresses are decoded ahead of the RAM window and never set err:
  - Write to 32'hF000_0000: con_data<=wdata[7:0], con_valid pulses 1 cycle in RESP.
  - Read of 32'hF000_0004: free-running 32-bit cycle counter (reset 0, wraps at 2^32), sampled in ACCESS.
  - Read of 32'hF000_0000: returns 0.
- Undefined: con_valid/con_data tied 0, no counter logic; these addresses are treated as out-of-window.

Decomposition:
- Shared package xrv_pkg: dmem_state_t enum {IDLE,WAIT,ACCESS,RESP}; MMIO_CON_ADDR, MMIO_CYC_ADDR localparams.
- Sub-module xrv_dmem_ram: DEPTH x 4-lane byte-enable synchronous RAM; one read/write port; registered read.

Test Plan:
- WAIT_CYCLES=0, write 32'hDEADBEEF be=4'hF at 32'h0001_0010, then read it back -> each ready 2 cycles after req rises; d_rd_data=32'hDEADBEEF.
- Write 32'h0000_5A00 be=4'h2 over that word, then read -> 32'hDEAD5AEF; other lanes unchanged.
- WAIT_CYCLES=3, read -> ready at N+5; exactly one pulse; no ready at N+6 while req falls.
- Read 32'h0000_0100, then write 32'h0002_0000 -> first read returns 0; err=1, err_addr=32'h0000_0100 (not overwritten); both accesses still complete.
- Assert rst in WAIT with a read pending -> no d_rd_ready; all outputs 0; a new read after reset completes normally with RAM data intact.
- With XRV_DMEM_MMIO_EN, write 32'h41 to 32'hF000_0000 and read 32'hF000_0004 twice -> con_valid 1 cycle, con_data=8'h41; second counter value exceeds the first by the cycle gap between their ACCESS cycles; err stays 0.

Source files
------------

// File: rtl/xrv_pkg.sv
// Shared types and addresses for the xrv data-memory responder.
package xrv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } dmem_state_t;

  localparam logic [31:0] MMIO_CON_ADDR = 32'hF000_0000;
  localparam logic [31:0] MMIO_CYC_ADDR = 32'hF000_0004;

endpackage

// File: rtl/xrv_dmem_ram.sv
// Single-port synchronous RAM, 32-bit words with four byte-lane write enables.
module xrv_dmem_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Read data register only updates on a read, so it holds between accesses.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/xrv_dmem.sv
// Data-memory responder for the d_* load/store port with wait states and window checking.
// Define XRV_DMEM_MMIO_EN to add the console byte and cycle-counter registers.
module xrv_dmem
  import xrv_pkg::*;
#(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE        = 32'h0001_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic        d_wr_req,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wr_data,
  output logic        d_wr_ready,
  input  logic        d_rd_req,
  output logic        d_rd_ready,
  output logic [31:0] d_rd_data,
  output logic        err,
  output logic [31:0] err_addr,
  output logic        con_valid,
  output logic [7:0]  con_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  dmem_state_t state;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        op_wr_q;
  logic        rd_sel_ram_q;
  logic [31:0] rd_hold_q;

  logic [31:0] offset;
  logic        in_window;
  logic        is_mmio;
  logic        ram_hit;
  logic        out_of_window;
  logic [31:0] mmio_rdata;
  logic [31:0] ram_rdata;

  assign offset        = addr_q - BASE;
  assign in_window     = offset < 32'(DEPTH * 4);
  assign ram_hit       = in_window && !is_mmio;
  assign out_of_window = !in_window && !is_mmio;

  // RAM output is only live in the RESP cycle; afterwards the captured copy is shown.
  assign d_rd_data = rd_sel_ram_q ? ram_rdata : rd_hold_q;

  xrv_dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    ((state == ACCESS) && ram_hit),
    .we    (op_wr_q),
    .be    (be_q),
    .addr  (offset[AW+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

`ifdef XRV_DMEM_MMIO_EN
  logic [31:0] cyc_cnt_q;
  logic        is_con;
  logic        is_cyc;

  assign is_con     = addr_q == MMIO_CON_ADDR;
  assign is_cyc     = addr_q == MMIO_CYC_ADDR;
  assign is_mmio    = is_con || is_cyc;
  assign mmio_rdata = is_cyc ? cyc_cnt_q : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      con_valid <= 1'b0;
      con_data  <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      con_valid <= (state == ACCESS) && op_wr_q && is_con;
      if ((state == ACCESS) && op_wr_q && is_con) con_data <= wdata_q[7:0];
    end
  end
`else
  assign is_mmio    = 1'b0;
  assign mmio_rdata = 32'h0;
  assign con_valid  = 1'b0;
  assign con_data   = 8'h0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      op_wr_q      <= 1'b0;
      rd_sel_ram_q <= 1'b0;
      rd_hold_q    <= '0;
      d_wr_ready   <= 1'b0;
      d_rd_ready   <= 1'b0;
      err          <= 1'b0;
      err_addr     <= '0;
    end else begin
      d_wr_ready <= 1'b0;
      d_rd_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (d_wr_req || d_rd_req) begin
            addr_q  <= d_addr;
            wdata_q <= d_wr_data;
            be_q    <= d_be;
            op_wr_q <= d_wr_req;
            cnt_q   <= 4'(WAIT_CYCLES);
            state   <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state <= ACCESS;
        end
        ACCESS: begin
          rd_sel_ram_q <= !op_wr_q && ram_hit;
          if (!op_wr_q && !ram_hit) rd_hold_q <= mmio_rdata;
          if (out_of_window && !err) begin
            err      <= 1'b1;
            err_addr <= addr_q;
          end
          d_wr_ready <= op_wr_q;
          d_rd_ready <= !op_wr_q;
          state      <= RESP;
        end
        RESP: begin
          if (rd_sel_ram_q) rd_hold_q <= ram_rdata;
          rd_sel_ram_q <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xrv_dmem.sv
// Self-checking bench for xrv_dmem: instance 0 has no wait states, instance 1 has three.
module tb_xrv_dmem;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int unsigned DEPTH = 4096;

  logic        clk;
  logic        rst      [2];
  logic [31:0] addr     [2];
  logic [31:0] wdata    [2];
  logic [3:0]  be       [2];
  logic        wr_req   [2];
  logic        rd_req   [2];
  logic        wr_rdy   [2];
  logic        rd_rdy   [2];
  logic [31:0] rd_data  [2];
  logic        err      [2];
  logic [31:0] err_addr [2];
  logic        con_v    [2];
  logic [7:0]  con_d    [2];

  int checks = 0;
  int fails  = 0;
  int unsigned tb_cyc = 0;

  // Reference model: word store keyed per instance, sticky error per instance.
  logic [31:0] mem_m [int];
  bit          err_m [2];
  logic [31:0] err_addr_m [2];

  xrv_dmem #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .d_addr(addr[0]), .d_wr_req(wr_req[0]), .d_be(be[0]),
    .d_wr_data(wdata[0]), .d_wr_ready(wr_rdy[0]), .d_rd_req(rd_req[0]),
    .d_rd_ready(rd_rdy[0]), .d_rd_data(rd_data[0]), .err(err[0]), .err_addr(err_addr[0]),
    .con_valid(con_v[0]), .con_data(con_d[0])
  );

  xrv_dmem #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .d_addr(addr[1]), .d_wr_req(wr_req[1]), .d_be(be[1]),
    .d_wr_data(wdata[1]), .d_wr_ready(wr_rdy[1]), .d_rd_req(rd_req[1]),
    .d_rd_ready(rd_rdy[1]), .d_rd_data(rd_data[1]), .err(err[1]), .err_addr(err_addr[1]),
    .con_valid(con_v[1]), .con_data(con_d[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  function automatic bit in_win(input logic [31:0] a);
    return longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + longint'(DEPTH) * 4;
  endfunction

  function automatic bit is_mmio_addr(input logic [31:0] a);
`ifdef XRV_DMEM_MMIO_EN
    return a == 32'hF000_0000 || a == 32'hF000_0004;
`else
    return 1'b0;
`endif
  endfunction

  // Applies one access to the model and returns the data a read should produce.
  function automatic logic [31:0] model_access(input int u, input bit wr, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [3:0] b);
    int key;
    logic [31:0] w;
    if (is_mmio_addr(a)) return 32'h0;
    if (!in_win(a)) begin
      if (!err_m[u]) begin
        err_m[u] = 1'b1;
        err_addr_m[u] = a;
      end
      return 32'h0;
    end
    key = u * int'(DEPTH) + int'((a - BASE) >> 2);
    w = mem_m.exists(key) ? mem_m[key] : 32'h0;
    if (wr) begin
      for (int i = 0; i < 4; i++) if (b[i]) w[8*i +: 8] = wd[8*i +: 8];
      mem_m[key] = w;
    end
    return w;
  endfunction

  // Drives one request, waits for ready, drops the request, and watches the following cycle.
  task automatic do_req(input int u, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, output int lat, output logic [31:0] rdata,
                        output int unsigned rcyc, output logic cv, output logic [7:0] cd,
                        output logic after);
    bit got = 0;
    @(posedge clk);
    #1;
    addr[u] = a;
    wdata[u] = wd;
    be[u] = b;
    wr_req[u] = wr;
    rd_req[u] = !wr;
    lat = 0;
    rdata = 'x;
    rcyc = 0;
    cv = 1'b0;
    cd = 8'h0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wr ? wr_rdy[u] : rd_rdy[u]) begin
        got = 1;
        rdata = rd_data[u];
        rcyc = tb_cyc;
        cv = con_v[u];
        cd = con_d[u];
        break;
      end
      lat++;
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL req_timeout inst=%0d addr=%h: no ready within 40 cycles", u, a);
    end
    @(posedge clk);
    #1;
    wr_req[u] = 1'b0;
    rd_req[u] = 1'b0;
    @(negedge clk);
    after = wr_rdy[u] | rd_rdy[u] | con_v[u];
  endtask

  task automatic test_reset;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1;
      addr[u] = '0;
      wdata[u] = '0;
      be[u] = '0;
      wr_req[u] = 1'b0;
      rd_req[u] = 1'b0;
      err_m[u] = 1'b0;
      err_addr_m[u] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({wr_rdy[u], rd_rdy[u], rd_data[u], err[u], err_addr[u], con_v[u], con_d[u]} !== 76'h0)
      begin
        fails++;
        $display("FAIL reset_outputs inst=%0d got rd_data=%h err=%b err_addr=%h con=%b/%h want 0",
                 u, rd_data[u], err[u], err_addr[u], con_v[u], con_d[u]);
      end
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    logic [31:0] rd, exp;
    int unsigned rc;
    logic cv, after;
    logic [7:0] cd;
    void'(model_access(0, 1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF));
    do_req(0, 1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, lat, rd, rc, cv, cd, after);
    checks++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL basic_wr_latency got %0d want 2", lat);
    end
    exp = model_access(0, 0, 32'h0001_0010, 32'h0, 4'h0);
    do_req(0, 0, 32'h0001_0010, 32'h0, 4'h0, lat, rd, rc, cv, cd, after);
    checks++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL basic_rd_latency got %0d want 2", lat);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF || rd !== exp) begin
      fails++;
      $display("FAIL basic_rd_data got %h want %h", rd, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_byte_lane;
    int lat;
    logic [31:0] rd;
    int unsigned rc;
    logic cv, after;
    logic [7:0] cd;
    void'(model_access(0, 1, 32'h0001_0010, 32'h0000_5A00, 4'h2));
    do_req(0, 1, 32'h0001_0010, 32'h0000_5A00, 4'h2, lat, rd, rc, cv, cd, after);
    do_req(0, 0, 32'h0001_0012, 32'h0, 4'h0, lat, rd, rc, cv, cd, after);
    checks++;
    if (rd !== 32'hDEAD_5AEF) begin
      fails++;
      $display("FAIL byte_lane_merge got %h want %h", rd, 32'hDEAD_5AEF);
    end
  endtask

  task automatic test_random;
    logic [31:0] waddr [8];
    int lat;
    logic [31:0] rd, exp, a, d;
    logic [3:0] b;
    int unsigned rc;
    logic cv, after;
    logic [7:0] cd;
    bit wr;
    for (int i = 0; i < 8; i++) begin
      waddr[i] = BASE + 32'((i * 500 + $urandom_range(0, 499)) * 4);
      d = $urandom;
      void'(model_access(0, 1, waddr[i], d, 4'hF));
      do_req(0, 1, waddr[i], d, 4'hF, lat, rd, rc, cv, cd, after);
    end
    for (int n = 0; n < 40; n++) begin
      a = waddr[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      d = $urandom;
      b = 4'($urandom);
      exp = model_access(0, wr, a, d, b);
      do_req(0, wr, a, d, b, lat, rd, rc, cv, cd, after);
      checks++;
      if (lat !== 2) begin
        fails++;
        $display("FAIL random_latency op=%0d got %0d want 2", n, lat);
      end
      if (!wr) begin
        checks++;
        if (rd !== exp) begin
          fails++;
          $display("FAIL random_rd_data op=%0d addr=%h got %h want %h", n, a, rd, exp);
        end
      end
    end
    checks++;
    if (err[0] !== 1'b0) begin
      fails++;
      $display("FAIL random_no_err got %b want 0", err[0]);
    end
  endtask

  task automatic test_wait_latency;
    int lat;
    logic [31:0] rd, exp, d;
    int unsigned rc;
    logic cv, after;
    logic [7:0] cd;
    d = $urandom;
    void'(model_access(1, 1, 32'h0001_0020, d, 4'hF));
    do_req(1, 1, 32'h0001_0020, d, 4'hF, lat, rd, rc, cv, cd, after);
    checks++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL wait_wr_latency got %0d want 5", lat);
    end
    exp = model_access(1, 0, 32'h0001_0020, 32'h0, 4'h0);
    do_req(1, 0, 32'h0001_0020, 32'h0, 4'h0, lat, rd, rc, cv, cd, after);
    checks++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL wait_rd_latency got %0d want 5", lat);
    end
    checks++;
    if (rd !== exp) begin
      fails++;
      $display("FAIL wait_rd_data got %h want %h", rd, exp);
    end
    checks++;
    if (after !== 1'b0) begin
      fails++;
      $display("FAIL wait_single_pulse got ready in following cycle=%b want 0", after);
    end
  endtask

  task automatic test_out_of_window;
    int lat;
    logic [31:0] rd, exp;
    int unsigned rc;
    logic cv, after;
    logic [7:0] cd;
    exp = model_access(1, 0, 32'h0000_0100, 32'h0, 4'h0);
    do_req(1, 0, 32'h0000_0100, 32'h0, 4'h0, lat, rd, rc, cv, cd, after);
    checks++;
    if (lat !== 5 || rd !== exp) begin
      fails++;
      $display("FAIL oow_read got lat=%0d data=%h want lat=5 data=%h", lat, rd, exp);
    end
    checks++;
    if (err[1] !== err_m[1] || err_addr[1] !== err_addr_m[1]) begin
      fails++;
      $display("FAIL oow_err_first got %b/%h want %b/%h", err[1], err_addr[1], err_m[1],
               err_addr_m[1]);
    end
    void'(model_access(1, 1, 32'h0002_0000, 32'h1234_5678, 4'hF));
    do_req(1, 1, 32'h0002_0000, 32'h1234_5678, 4'hF, lat, rd, rc, cv, cd, after);
    checks++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL oow_write_complete got lat=%0d want 5", lat);
    end
    checks++;
    if (err[1] !== 1'b1 || err_addr[1] !== 32'h0000_0100) begin
      fails++;
      $display("FAIL oow_err_sticky got %b/%h want 1/%h", err[1], err_addr[1], 32'h0000_0100);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [31:0] rd, exp;
    int unsigned rc;
    logic cv, after;
    logic [7:0] cd;
    bit seen = 0;
    @(posedge clk);
    #1;
    addr[1] = 32'h0001_0020;
    rd_req[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    err_m[1] = 1'b0;
    err_addr_m[1] = '0;
    #1;
    checks++;
    if ({wr_rdy[1], rd_rdy[1], rd_data[1], err[1], err_addr[1], con_v[1], con_d[1]} !== 76'h0)
    begin
      fails++;
      $display("FAIL midreset_outputs got rd_data=%h err=%b err_addr=%h want 0", rd_data[1],
               err[1], err_addr[1]);
    end
    rd_req[1] = 1'b0;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_rdy[1] || wr_rdy[1]) seen = 1;
    end
    checks++;
    if (seen) begin
      fails++;
      $display("FAIL midreset_no_ready got ready=1 want 0");
    end
    exp = model_access(1, 0, 32'h0001_0020, 32'h0, 4'h0);
    do_req(1, 0, 32'h0001_0020, 32'h0, 4'h0, lat, rd, rc, cv, cd, after);
    checks++;
    if (lat !== 5 || rd !== exp) begin
      fails++;
      $display("FAIL midreset_reread got lat=%0d data=%h want lat=5 data=%h", lat, rd, exp);
    end
  endtask

  task automatic test_mmio;
    int lat;
    logic [31:0] rd, v1, v2;
    int unsigned rc, rc1, rc2;
    logic cv, after;
    logic [7:0] cd;
    void'(model_access(0, 1, 32'hF000_0000, 32'h41, 4'hF));
    do_req(0, 1, 32'hF000_0000, 32'h0000_0041, 4'hF, lat, rd, rc, cv, cd, after);
`ifdef XRV_DMEM_MMIO_EN
    checks++;
    if (cv !== 1'b1 || cd !== 8'h41 || after !== 1'b0) begin
      fails++;
      $display("FAIL mmio_console got valid=%b data=%h next=%b want 1/41/0", cv, cd, after);
    end
    do_req(0, 0, 32'hF000_0004, 32'h0, 4'h0, lat, v1, rc1, cv, cd, after);
    repeat ($urandom_range(1, 9)) @(posedge clk);
    do_req(0, 0, 32'hF000_0004, 32'h0, 4'h0, lat, v2, rc2, cv, cd, after);
    checks++;
    if (v2 - v1 !== 32'(rc2 - rc1)) begin
      fails++;
      $display("FAIL mmio_cycle_delta got %0d want %0d", v2 - v1, rc2 - rc1);
    end
    do_req(0, 0, 32'hF000_0000, 32'h0, 4'h0, lat, rd, rc, cv, cd, after);
    checks++;
    if (rd !== 32'h0 || lat !== 2) begin
      fails++;
      $display("FAIL mmio_con_read got lat=%0d data=%h want lat=2 data=0", lat, rd);
    end
`else
    checks++;
    if (cv !== 1'b0 || cd !== 8'h0) begin
      fails++;
      $display("FAIL nommio_console got valid=%b data=%h want 0/00", cv, cd);
    end
    void'(model_access(0, 0, 32'hF000_0004, 32'h0, 4'h0));
    do_req(0, 0, 32'hF000_0004, 32'h0, 4'h0, lat, v1, rc1, cv, cd, after);
    checks++;
    if (v1 !== 32'h0) begin
      fails++;
      $display("FAIL nommio_cycle_read got %h want 0", v1);
    end
`endif
    checks++;
    if (err[0] !== err_m[0] || err_addr[0] !== err_addr_m[0]) begin
      fails++;
      $display("FAIL mmio_err got %b/%h want %b/%h", err[0], err_addr[0], err_m[0],
               err_addr_m[0]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_byte_lane;
    test_random;
    test_wait_latency;
    test_out_of_window;
    test_reset_mid;
    test_mmio;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
